// File: rtl/navigate_gen.sv
// Maze navigation sequencer: sequences heading changes and forward moves,
// ramps an unsigned forward-speed setpoint with clamping, stops at the Nth
// qualifying side opening, and reports completion, abort and heading timeout.
module navigate_gen #(
  parameter int SPD_W          = 11,
  parameter int MAX_SPD        = 672,
  parameter int MIN_SPD        = 208,
  parameter int ACC_INC        = 24,
  parameter int DEC_SHIFT      = 1,
  parameter int FAST_DEC_SHIFT = 3,
  parameter int FUSION_THR     = MAX_SPD / 2,
  parameter int CNT_W          = 3,
  parameter int TMO_W          = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             strt_hdng,
  input  logic             strt_mv,
  input  logic             stp_lft,
  input  logic             stp_rght,
  input  logic [CNT_W-1:0] stp_cnt,
  input  logic             abort,
  input  logic             hdng_rdy,
  input  logic             at_hdng,
  input  logic             lft_opn,
  input  logic             rght_opn,
  input  logic             frwrd_opn,
  output logic             mv_cmplt,
  output logic             nav_err,
  output logic             moving,
  output logic             en_fusion,
  output logic [SPD_W-1:0] frwrd_spd
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HEADING  = 3'd1,
    ACCEL    = 3'd2,
    STOP     = 3'd3,
    FASTSTOP = 3'd4
  } state_t;

  localparam logic [SPD_W:0]   ACC_E     = (SPD_W+1)'(ACC_INC);
  localparam logic [SPD_W:0]   MAX_E     = (SPD_W+1)'(MAX_SPD);
  localparam logic [SPD_W-1:0] MAX_V     = SPD_W'(MAX_SPD);
  localparam logic [SPD_W-1:0] MIN_V     = SPD_W'(MIN_SPD);
  localparam logic [SPD_W-1:0] FUSION_V  = SPD_W'(FUSION_THR);
  localparam logic [SPD_W-1:0] DEC_STEP  = SPD_W'(ACC_INC << DEC_SHIFT);
  localparam logic [SPD_W-1:0] FDEC_STEP = SPD_W'(ACC_INC << FAST_DEC_SHIFT);
  localparam logic [TMO_W-1:0] TMO_MAX   = {TMO_W{1'b1}};

  state_t             state_q, state_d;
  logic [SPD_W-1:0]   spd_q, spd_d;
  logic [CNT_W-1:0]   opn_cnt_q, opn_cnt_d;
  logic [CNT_W-1:0]   stp_cnt_q, stp_cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               lft_hist_q, rght_hist_q, hdng_hist_q;

  logic               hdng_rise;
  logic               qual_rise;

  // Speed increment computed one bit wider so it clamps instead of wrapping.
  function automatic logic [SPD_W-1:0] sat_inc(input logic [SPD_W-1:0] s);
    logic [SPD_W:0] sum;
    sum = {1'b0, s} + ACC_E;
    if (sum > MAX_E) return MAX_V;
    return sum[SPD_W-1:0];
  endfunction

  // Speed decrement floored at zero.
  function automatic logic [SPD_W-1:0] sat_dec(input logic [SPD_W-1:0] s,
                                               input logic [SPD_W-1:0] step);
    if (s <= step) return '0;
    return s - step;
  endfunction

  assign hdng_rise = at_hdng & ~hdng_hist_q;
  // Left and right rises in the same cycle collapse into a single event.
  assign qual_rise = (lft_opn & ~lft_hist_q & stp_lft) |
                     (rght_opn & ~rght_hist_q & stp_rght);

  assign frwrd_spd = spd_q;
  assign en_fusion = (spd_q > FUSION_V);

  // Next-state, datapath and completion/status decode for the sequencer.
  always_comb begin
    state_d   = state_q;
    spd_d     = spd_q;
    opn_cnt_d = opn_cnt_q;
    stp_cnt_d = stp_cnt_q;
    tmo_d     = tmo_q;
    mv_cmplt  = 1'b0;
    nav_err   = 1'b0;
    moving    = 1'b0;
    case (state_q)
      IDLE: begin
        if (strt_mv) begin
          spd_d     = MIN_V;
          stp_cnt_d = stp_cnt;
          opn_cnt_d = '0;
          state_d   = ACCEL;
        end else if (strt_hdng) begin
          tmo_d   = '0;
          state_d = HEADING;
        end
      end
      HEADING: begin
        moving = 1'b1;
        if (tmo_q != TMO_MAX) tmo_d = tmo_q + 1'b1;
        if (abort || (tmo_q == TMO_MAX)) begin
          mv_cmplt = 1'b1;
          nav_err  = 1'b1;
          moving   = 1'b0;
          state_d  = IDLE;
        end else if (hdng_rise) begin
          mv_cmplt = 1'b1;
          moving   = 1'b0;
          state_d  = IDLE;
        end
      end
      ACCEL: begin
        moving = 1'b1;
        if (hdng_rdy) spd_d = sat_inc(spd_q);
        if (abort || !frwrd_opn) begin
          state_d = FASTSTOP;
        end else if (qual_rise) begin
          if (opn_cnt_q == stp_cnt_q) state_d = STOP;
          else                        opn_cnt_d = opn_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (abort) begin
          moving  = 1'b1;
          state_d = FASTSTOP;
        end else if (spd_q == '0) begin
          mv_cmplt = 1'b1;
          state_d  = IDLE;
        end else begin
          moving = 1'b1;
          if (hdng_rdy) spd_d = sat_dec(spd_q, DEC_STEP);
        end
      end
      FASTSTOP: begin
        if (spd_q == '0) begin
          mv_cmplt = 1'b1;
          state_d  = IDLE;
        end else begin
          moving = 1'b1;
          if (hdng_rdy) spd_d = sat_dec(spd_q, FDEC_STEP);
        end
      end
      default: state_d = FASTSTOP;
    endcase
  end

  // State, speed, counters and edge-detect history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      spd_q       <= '0;
      opn_cnt_q   <= '0;
      stp_cnt_q   <= '0;
      tmo_q       <= '0;
      lft_hist_q  <= 1'b1;
      rght_hist_q <= 1'b1;
      hdng_hist_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      spd_q       <= spd_d;
      opn_cnt_q   <= opn_cnt_d;
      stp_cnt_q   <= stp_cnt_d;
      tmo_q       <= tmo_d;
      lft_hist_q  <= lft_opn;
      rght_hist_q <= rght_opn;
      hdng_hist_q <= at_hdng;
    end
  end

endmodule

// File: doc/navigate_gen.md
Name: navigate_gen

Overview:
- Parametrised next-generation maze navigation sequencer.
- Sits between the command/maze-solver layer and PID/inertial integration.
- Sequences heading changes and forward moves, and ramps an unsigned forward-speed setpoint.
- Over the previous generation it adds: parametrised speed width and profile, speed clamping at max, stop at the Nth qualifying side opening, an abort input, a heading timeout and an error flag.

Parameters:
- SPD_W, 11: width of frwrd_spd.
- MAX_SPD, 672 (0x2A0): speed ceiling; increments clamp here.
- MIN_SPD, 208 (0x0D0): speed loaded on strt_mv.
- ACC_INC, 24: speed increment per hdng_rdy while accelerating.
- DEC_SHIFT, 1: normal decel step = ACC_INC<<DEC_SHIFT.
- FAST_DEC_SHIFT, 3: fast decel step = ACC_INC<<FAST_DEC_SHIFT.
- FUSION_THR, MAX_SPD/2: en_fusion asserted when frwrd_spd > FUSION_THR.
- CNT_W, 3: width of the opening-skip count.
- TMO_W, 20: heading timeout counter width; timeout after 2^TMO_W-1 cycles in HEADING.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- strt_hdng  in  1  start heading change (accepted in IDLE only).
- strt_mv  in  1  start forward move (accepted in IDLE only).
- stp_lft  in  1  qualify left-opening rises as stop events.
- stp_rght  in  1  qualify right-opening rises as stop events.
- stp_cnt  in  CNT_W  number of qualifying openings to pass before stopping; latched on strt_mv.
- abort  in  1  abort the current operation.
- hdng_rdy  in  1  pacing strobe; speed changes only on this strobe.
- at_hdng  in  1  from PID: heading reached.
- lft_opn, rght_opn, frwrd_opn  in  1 each  IR opening indications.
- mv_cmplt  out  1  one-cycle pulse on completion, abort or timeout.
- nav_err  out  1  one-cycle pulse, coincident with mv_cmplt, on heading abort or timeout.
- moving  out  1  enables PID/integrator integration.
- en_fusion  out  1  frwrd_spd > FUSION_THR (combinational).
- frwrd_spd  out  SPD_W  forward speed setpoint.

Behaviour:
- Reset and clocking:
  - Single clock clk; reset rst_n is asynchronous, active-low.
  - Reset state: IDLE, frwrd_spd=0, opn_cnt=0, timeout counter=0.
  - Reset values of the edge-detect flops: lft_opn/rght_opn history = 1 (an opening present at reset is not a rise); at_hdng history = 0.
  - mv_cmplt, nav_err and moving are 0 after reset.
- States: IDLE, HEADING, ACCEL, STOP, FASTSTOP. An illegal encoding goes to FASTSTOP.
- IDLE:
  - strt_mv: frwrd_spd<=MIN_SPD, latch stp_cnt, opn_cnt<=0, go to ACCEL.
  - strt_hdng (without strt_mv): clear the timeout counter, go to HEADING.
  - strt_mv wins if both are asserted. abort is ignored in IDLE.
- HEADING:
  - moving=1.
  - at_hdng rising edge: mv_cmplt=1, moving=0 that cycle, go to IDLE.
  - abort, or timeout counter reaching 2^TMO_W-1: mv_cmplt=1, nav_err=1, go to IDLE.
  - Priority: abort/timeout over at_hdng rise.
- ACCEL:
  - moving=1.
  - On hdng_rdy: frwrd_spd<=min(frwrd_spd+ACC_INC, MAX_SPD). The sum is computed at SPD_W+1 bits, so there is no wrap.
  - Transition priority: abort or !frwrd_opn -> FASTSTOP; then qualifying rise -> opening logic.
  - Qualifying rise = (lft rise & stp_lft) | (rght rise & stp_rght). Simultaneous left and right rises count once.
  - On a qualifying rise: if opn_cnt==latched stp_cnt go to STOP, else opn_cnt<=opn_cnt+1 and stay in ACCEL.
- STOP:
  - abort -> FASTSTOP.
  - Else if frwrd_spd==0: mv_cmplt=1, go to IDLE.
  - Else: moving=1; on hdng_rdy subtract ACC_INC<<DEC_SHIFT, floored at 0.
- FASTSTOP:
  - If frwrd_spd==0: mv_cmplt=1, go to IDLE.
  - Else: moving=1; on hdng_rdy subtract ACC_INC<<FAST_DEC_SHIFT, floored at 0.
- Timing:
  - The completion pulse occurs in the cycle the zero speed is observed, so it is 1 cycle after the final decrement.
  - Edge detection uses a 1-cycle history, so a rise is seen in the cycle the input first reads high.
- nav_err is never asserted for forward moves; an aborted move completes normally via FASTSTOP.

Test Plan:
- Accel clamp: strt_mv, then 20 hdng_rdy pulses with frwrd_opn=1 -> frwrd_spd 208, 232, ... 664, then 672 (clamped), stays 672; en_fusion rises when spd first exceeds 336 (at 352).
- Normal stop at 2nd left opening: stp_cnt=1, stp_lft=1, at spd=672 give two lft_opn rises -> first ignored (opn_cnt=1), second enters STOP; 14 hdng_rdy pulses decrement 48 each to 0; next cycle mv_cmplt pulse, nav_err=0, moving=0.
- Fast stop: at spd=672 drop frwrd_opn -> FASTSTOP; spd 480, 288, 96, 0 (floored) over 4 hdng_rdy pulses; then mv_cmplt.
- Heading: strt_hdng, at_hdng rises after 100 cycles -> mv_cmplt 1 cycle, moving drops the same cycle; at_hdng held high afterwards causes no second pulse.
- Heading abort/timeout: with TMO_W=4, strt_hdng and at_hdng held 0 -> mv_cmplt and nav_err pulse after 15 cycles in HEADING; separate run with abort at cycle 3 -> immediate pulses.
- Priorities: strt_mv with strt_hdng in the same cycle -> ACCEL; in ACCEL, abort with a qualifying rise in the same cycle -> FASTSTOP; rst_n low mid-STOP -> frwrd_spd=0 and IDLE asynchronously.
